// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM/redirect-class types and address alignment helper for the fetch PC unit
package pc_pkg;
  typedef enum logic {IDLE, PENDING} state_t;
  typedef enum logic [1:0] {NONE = 2'd0, JMP = 2'd1, BR = 2'd2, EXC = 2'd3} rclass_t;
  function automatic logic [63:0] align_addr(input logic [63:0] addr, input int unsigned incr);
    return addr & ~(64'(incr) - 64'd1);
  endfunction
endpackage

// File: rtl/redirect_arb.sv
// redirect_arb: fixed-priority (exc > br > jmp) pick of redirect target/class; ports exc_req, br_taken/br_target, jmp_req/jmp_target -> target, cls
module redirect_arb import pc_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int INCR = 4,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 'h80
) (
  input  logic             exc_req,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_req,
  input  logic [WIDTH-1:0] jmp_target,
  output logic [WIDTH-1:0] target,
  output rclass_t          cls
);
  logic [WIDTH-1:0] br_al, jmp_al;
  assign br_al  = WIDTH'(align_addr(64'(br_target), INCR));
  assign jmp_al = WIDTH'(align_addr(64'(jmp_target), INCR));
  always_comb begin
    cls    = exc_req ? EXC : br_taken ? BR : jmp_req ? JMP : NONE;
    target = exc_req ? EXC_VECTOR : br_taken ? br_al : jmp_req ? jmp_al : '0;
  end
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: fetch PC register with prioritized exc/br/jmp redirect held across stall; ports clk, rst, stall, requests/targets -> pc, pc_seq, redirect, pend
module pc_next_unit import pc_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int INCR = 4,
  parameter logic [WIDTH-1:0] RESET_PC = 'h0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 'h80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc_req,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_req,
  input  logic [WIDTH-1:0] jmp_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             redirect,
  output logic             pend
);
  state_t           state, state_nxt;
  rclass_t          win_cls, held_cls, cur_cls;
  logic [WIDTH-1:0] win_tgt, held_tgt, cur_tgt;
  logic             take;
  redirect_arb #(.WIDTH(WIDTH), .INCR(INCR), .EXC_VECTOR(EXC_VECTOR)) u_arb (
    .exc_req(exc_req), .br_taken(br_taken), .br_target(br_target),
    .jmp_req(jmp_req), .jmp_target(jmp_target), .target(win_tgt), .cls(win_cls)
  );
  assign pc_seq = pc + WIDTH'(INCR);
  always_comb begin
    take      = win_cls != NONE && (state == IDLE || win_cls >= held_cls);
    cur_cls   = take ? win_cls : held_cls;
    cur_tgt   = take ? win_tgt : held_tgt;
    state_nxt = stall && cur_cls != NONE ? PENDING : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      redirect <= 1'b0;
      pend     <= 1'b0;
      held_tgt <= '0;
      held_cls <= NONE;
    end else begin
      state    <= state_nxt;
      pend     <= state_nxt == PENDING;
      redirect <= !stall && cur_cls != NONE;
      held_cls <= stall ? cur_cls : NONE;
      held_tgt <= stall ? cur_tgt : '0;
      if (!stall) pc <= cur_cls != NONE ? cur_tgt : pc_seq;
    end
  end
endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;
  logic clk = 0;
  always #5 clk = ~clk;

  logic rst, stall, exc_req, br_taken, jmp_req, redirect, pend;
  logic [31:0] br_target, jmp_target, pc, pc_seq;
  logic rst8, redirect8, pend8;
  logic [7:0] pc8, pc_seq8;
  logic zero = 1'b0;
  logic [7:0] zero8 = 8'h0;

  pc_next_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .exc_req(exc_req), .br_taken(br_taken),
    .br_target(br_target), .jmp_req(jmp_req), .jmp_target(jmp_target),
    .pc(pc), .pc_seq(pc_seq), .redirect(redirect), .pend(pend)
  );

  pc_next_unit #(.WIDTH(8), .INCR(4), .RESET_PC(8'hFC), .EXC_VECTOR(8'h80)) dut8 (
    .clk(clk), .rst(rst8), .stall(zero), .exc_req(zero), .br_taken(zero),
    .br_target(zero8), .jmp_req(zero), .jmp_target(zero8),
    .pc(pc8), .pc_seq(pc_seq8), .redirect(redirect8), .pend(pend8)
  );

  int total = 0, passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic rst, stall, exc, br;
    logic [31:0] bt;
    logic jmp;
    logic [31:0] jt;
    logic [31:0] epc;
    logic ered, epend;
  } vec_t;

  vec_t v[$];

  task automatic add(input logic r, s, e, b, input logic [31:0] bt, input logic j,
                     input logic [31:0] jt, input logic [31:0] epc, input logic ered, epend);
    vec_t x;
    x.rst = r; x.stall = s; x.exc = e; x.br = b; x.bt = bt; x.jmp = j; x.jt = jt;
    x.epc = epc; x.ered = ered; x.epend = epend;
    v.push_back(x);
  endtask

  task automatic drive(input logic r, s, e, b, input logic [31:0] bt, input logic j, input logic [31:0] jt);
    rst = r; stall = s; exc_req = e; br_taken = b; br_target = bt; jmp_req = j; jmp_target = jt;
  endtask

  // Reference model: a held redirect is just a (valid, priority, address) record.
  int unsigned m_pc;
  bit m_hv, m_red;
  int m_hp;
  int unsigned m_ht;

  task automatic model_step(input logic r, s, e, b, input logic [31:0] bt, input logic j, input logic [31:0] jt);
    int p;
    int unsigned t;
    if (r) begin
      m_pc = 0; m_hv = 0; m_red = 0; m_hp = 0; m_ht = 0;
      return;
    end
    p = e ? 3 : b ? 2 : j ? 1 : 0;
    t = e ? 32'h80 : b ? (bt / 4) * 4 : (jt / 4) * 4;
    if (p > 0 && (!m_hv || p >= m_hp)) begin
      m_hv = 1; m_hp = p; m_ht = t;
    end
    m_red = 0;
    if (!s) begin
      if (m_hv) begin
        m_pc = m_ht; m_red = 1; m_hv = 0;
      end else m_pc = m_pc + 4;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    rst8 = 1;
    // reset, free run
    add(1,0,0,0,0,0,0, 32'h0, 0,0);
    add(1,0,0,0,0,0,0, 32'h0, 0,0);
    add(0,0,0,0,0,0,0, 32'h4, 0,0);
    add(0,0,0,0,0,0,0, 32'h8, 0,0);
    add(0,0,0,0,0,0,0, 32'hC, 0,0);
    add(0,0,0,0,0,0,0, 32'h10,0,0);
    // branch captured under stall, aligned on release
    add(0,1,0,1,32'h302,0,0, 32'h10, 0,1);
    add(0,1,0,0,0,0,0,       32'h10, 0,1);
    add(0,1,0,0,0,0,0,       32'h10, 0,1);
    add(0,0,0,0,0,0,0,       32'h300,1,0);
    add(0,0,0,0,0,0,0,       32'h304,0,0);
    // simultaneous requests: exception wins
    add(0,0,0,0,0,1,32'h40,  32'h40, 1,0);
    add(0,0,1,1,32'h200,1,32'h1000, 32'h80, 1,0);
    add(0,0,0,0,0,0,0,       32'h84, 0,0);
    // pending overwrite rules
    add(0,1,0,1,32'h100,0,0, 32'h84, 0,1);
    add(0,1,0,0,0,1,32'h500, 32'h84, 0,1);
    add(0,1,1,0,0,0,0,       32'h84, 0,1);
    add(0,0,0,0,0,0,0,       32'h80, 1,0);
    // reset mid-pending discards held jump
    add(0,1,0,0,0,1,32'h400, 32'h80, 0,1);
    add(1,1,0,0,0,0,0,       32'h0,  0,0);
    add(0,0,0,0,0,0,0,       32'h4,  0,0);
    add(0,0,0,0,0,0,0,       32'h8,  0,0);
    // same-cycle replacement at release; lower-priority request on release dropped
    add(0,1,0,0,0,1,32'h600, 32'h8,  0,1);
    add(0,0,0,1,32'h700,0,0, 32'h700,1,0);
    add(0,1,0,1,32'h900,0,0, 32'h700,0,1);
    add(0,0,0,0,0,1,32'h20,  32'h900,1,0);
    add(0,0,0,0,0,0,0,       32'h904,0,0);

    foreach (v[i]) begin
      drive(v[i].rst, v[i].stall, v[i].exc, v[i].br, v[i].bt, v[i].jmp, v[i].jt);
      if (i == 1) rst8 = 0;
      @(posedge clk); #1;
      chk($sformatf("vec%0d pc", i), pc, v[i].epc);
      chk($sformatf("vec%0d pc_seq", i), pc_seq, v[i].epc + 32'd4);
      chk($sformatf("vec%0d redirect", i), 32'(redirect), 32'(v[i].ered));
      chk($sformatf("vec%0d pend", i), 32'(pend), 32'(v[i].epend));
      if (i == 0) chk("wrap reset pc", 32'(pc8), 32'hFC);
      if (i == 1) begin
        chk("wrap pc", 32'(pc8), 32'h00);
        chk("wrap pc_seq", 32'(pc_seq8), 32'h04);
        chk("wrap redirect", 32'(redirect8), 32'h0);
      end
    end

    // randomized run against the model
    drive(1, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int n = 0; n < 500; n++) begin
      logic r, s, e, b, j;
      logic [31:0] bt, jt;
      r = ($urandom_range(0, 40) == 0);
      s = $urandom_range(0, 1);
      e = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 3) == 0);
      bt = $urandom;
      jt = $urandom;
      drive(r, s, e, b, bt, j, jt);
      model_step(r, s, e, b, bt, j, jt);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d pc", n), pc, m_pc);
      chk($sformatf("rnd%0d redirect", n), 32'(redirect), 32'(m_red));
      chk($sformatf("rnd%0d pend", n), 32'(pend), 32'(m_hv));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
